// File: rtl/rv32_pkg.sv
// Shared RV32 fetch-path types and constants for the instruction prefetch buffer.
package rv32_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] INSTR_BYTES = 32'd4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            filled;
    } fetch_entry_t;

    // Clear the two byte-offset bits of a fetch address.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/prefetch_ring.sv
// Prefetch ring storage: allocate (pc), fill (instr) and head read ports.
module prefetch_ring
    import rv32_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     clear,
    input  logic                     alloc_en,
    input  logic [$clog2(DEPTH)-1:0] alloc_idx,
    input  logic [XLEN-1:0]          alloc_pc,
    input  logic                     fill_en,
    input  logic [$clog2(DEPTH)-1:0] fill_idx,
    input  logic [XLEN-1:0]          fill_instr,
    input  logic [$clog2(DEPTH)-1:0] head_idx,
    output fetch_entry_t             head_entry
);

    logic [XLEN-1:0]  pc_mem    [DEPTH];
    logic [XLEN-1:0]  instr_mem [DEPTH];
    logic [DEPTH-1:0] filled;

    // Alloc and fill never target the same slot in one cycle: that would need a full ring.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            filled <= '0;
        end else if (clear) begin
            filled <= '0;
        end else begin
            if (alloc_en) filled[alloc_idx] <= 1'b0;
            if (fill_en)  filled[fill_idx]  <= 1'b1;
        end
    end

    // NOTE: payload arrays carry no reset; the filled bits alone decide what is visible.
    always_ff @(posedge clk) begin
        if (alloc_en) pc_mem[alloc_idx]   <= alloc_pc;
        if (fill_en)  instr_mem[fill_idx] <= fill_instr;
    end

    always_comb begin
        head_entry        = '0;
        head_entry.pc     = pc_mem[head_idx];
        head_entry.instr  = instr_mem[head_idx];
        head_entry.filled = filled[head_idx];
    end

endmodule

// File: rtl/instr_prefetch_buffer.sv
// In-order instruction prefetch queue: issues sequential fetches, collects responses, presents {instr, pc}.
module instr_prefetch_buffer
    import rv32_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            n_rst,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic            rsp_err
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;
    localparam int SW = PW + 1;

    typedef logic [PW-1:0] ptr_t;
    typedef logic [SW-1:0] sum_t;

    localparam ptr_t PTR_ONE   = ptr_t'(1);
    localparam sum_t SUM_ONE   = sum_t'(1);
    localparam sum_t SUM_DEPTH = sum_t'(DEPTH);

    ptr_t            head, fill, tail, drop_cnt;
    logic [XLEN-1:0] fetch_pc;
    logic            rsp_err_q;

    ptr_t            occupancy, in_flight;
    sum_t            pending_sum, squash_total, squash_drop;
    logic            full, empty, credit_ok;
    logic            issue, deq;
    logic            rsp_drop, rsp_fill, rsp_orphan;
    fetch_entry_t    head_entry;

    // Occupancy and full come from registered pointers only, so instr_ready never reaches imem_req_valid.
    assign occupancy = tail - head;
    assign in_flight = tail - fill;
    assign full      = (tail[IW-1:0] == head[IW-1:0]) && (tail[IW] != head[IW]);
    assign empty     = (tail == head);

    // Responses still owed to squashed requests hold ring credit until they arrive.
    assign pending_sum = {1'b0, drop_cnt} + {1'b0, occupancy};
    assign credit_ok   = pending_sum < SUM_DEPTH;

    assign imem_req_valid = n_rst && !full && !redirect && credit_ok;
    assign imem_req_addr  = fetch_pc;
    assign issue          = imem_req_valid && imem_req_ready;

    assign rsp_drop   = imem_rsp_valid && (drop_cnt != '0);
    assign rsp_fill   = imem_rsp_valid && (drop_cnt == '0) && (fill != tail);
    assign rsp_orphan = imem_rsp_valid && (drop_cnt == '0) && (fill == tail);

    // On redirect every outstanding response becomes a drop, minus one arriving right now.
    assign squash_total = {1'b0, in_flight} + {1'b0, drop_cnt};
    assign squash_drop  = (imem_rsp_valid && (squash_total != '0)) ? squash_total - SUM_ONE
                                                                    : squash_total;

    assign instr_valid = n_rst && !empty && head_entry.filled;
    assign instr       = head_entry.instr;
    assign instr_pc    = head_entry.pc;
    assign deq         = instr_valid && instr_ready;
    assign rsp_err     = rsp_err_q;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            head      <= '0;
            fill      <= '0;
            tail      <= '0;
            drop_cnt  <= '0;
            fetch_pc  <= RESET_PC;
            rsp_err_q <= 1'b0;
        end else begin
            if (rsp_orphan) rsp_err_q <= 1'b1;
            if (redirect) begin
                head     <= tail;
                fill     <= tail;
                drop_cnt <= ptr_t'(squash_drop);
                fetch_pc <= word_align(redirect_pc);
            end else begin
                if (issue) begin
                    tail     <= tail + PTR_ONE;
                    fetch_pc <= fetch_pc + INSTR_BYTES;
                end
                if (rsp_drop) drop_cnt <= drop_cnt - PTR_ONE;
                if (rsp_fill) fill     <= fill + PTR_ONE;
                if (deq)      head     <= head + PTR_ONE;
            end
        end
    end

    prefetch_ring #(
        .DEPTH (DEPTH)
    ) u_ring (
        .clk        (clk),
        .n_rst      (n_rst),
        .clear      (redirect),
        .alloc_en   (issue),
        .alloc_idx  (tail[IW-1:0]),
        .alloc_pc   (fetch_pc),
        .fill_en    (rsp_fill && !redirect),
        .fill_idx   (fill[IW-1:0]),
        .fill_instr (imem_rsp_data),
        .head_idx   (head[IW-1:0]),
        .head_entry (head_entry)
    );

endmodule
